// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer.
// FSM state encoding and bit-order selectors.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_chain.sv
// DEPTH-stage serial data chain with a parallel valid shadow chain.
// Both advance together on shift_en; clear empties them.
module shift_chain #(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             din,
  input  logic             vin,
  output logic [DEPTH-1:0] q,
  output logic [DEPTH-1:0] v
);

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (clear) begin
          q <= '0;
          v <= '0;
        end else if (shift_en) begin
          q <= din;
          v <= vin;
        end
      end
    end else begin : g_many
      always_ff @(posedge clk) begin
        if (clear) begin
          q <= '0;
          v <= '0;
        end else if (shift_en) begin
          q <= {q[DEPTH-2:0], din};
          v <= {v[DEPTH-2:0], vin};
        end
      end
    end
  endgenerate

endmodule

// File: rtl/shift_sequencer.sv
// Sequences a word through the shift chain, flushes it and
// reassembles the chain output into rx_word for loopback checks.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             dir,
  input  logic             abort,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             shift_en,
  output logic [IDX_W-1:0] bit_idx,
  output logic [DEPTH-1:0] q,
  output logic             serial_out,
  output logic [WIDTH-1:0] rx_word
);

  localparam int FL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [FL_W-1:0] LAST_FL = FL_W'(DEPTH - 1);

  state_t           state;
  logic [WIDTH-1:0] hold;
  logic             dir_r;
  logic [FL_W-1:0]  fl_cnt;
  logic [DEPTH-1:0] v;
  logic             in_xfer;
  logic             abort_hit;
  logic             chain_clr;
  logic             inj_bit;
  logic             din;
  logic             vin;

  assign in_xfer   = (state == SHIFT) || (state == FLUSH);
  assign abort_hit = abort && in_xfer;
  assign chain_clr = clear || abort_hit;

  assign inj_bit = (dir_r == DIR_MSB_FIRST) ?
                   hold[LAST_IDX - bit_idx] :
                   hold[bit_idx];

  assign din = (state == SHIFT) ? inj_bit : 1'b0;
  assign vin = (state == SHIFT);

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign shift_en   = in_xfer;
  assign serial_out = q[DEPTH-1];

  shift_chain #(
    .DEPTH(DEPTH)
  ) u_chain (
    .clk     (clk),
    .clear   (chain_clr),
    .shift_en(shift_en),
    .din     (din),
    .vin     (vin),
    .q       (q),
    .v       (v)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state   <= IDLE;
      hold    <= '0;
      dir_r   <= DIR_LSB_FIRST;
      bit_idx <= '0;
      fl_cnt  <= '0;
      rx_word <= '0;
    end else begin
      // an aborting edge keeps the partial word untouched
      if (v[DEPTH-1] && !abort_hit) begin
        if (dir_r == DIR_MSB_FIRST)
          rx_word <= {rx_word[WIDTH-2:0], serial_out};
        else
          rx_word <= {serial_out, rx_word[WIDTH-1:1]};
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            hold    <= data_in;
            dir_r   <= dir;
            bit_idx <= '0;
            fl_cnt  <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            bit_idx <= '0;
            state   <= IDLE;
          end else if (bit_idx == LAST_IDX) begin
            bit_idx <= '0;
            fl_cnt  <= '0;
            state   <= FLUSH;
          end else begin
            bit_idx <= bit_idx + 1'b1;
          end
        end
        FLUSH: begin
          if (abort) begin
            fl_cnt <= '0;
            state  <= IDLE;
          end else if (fl_cnt == LAST_FL) begin
            fl_cnt <= '0;
            state  <= DONE;
          end else begin
            fl_cnt <= fl_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboarded bench for shift_sequencer: expected words queued at
// start, checked against serial_out and rx_word by a monitor.
module tb_shift_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int IDX_W = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             clear = 1'b0;
  logic             start = 1'b0;
  logic             dir = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             busy;
  logic             done;
  logic             shift_en;
  logic [IDX_W-1:0] bit_idx;
  logic [DEPTH-1:0] q;
  logic             serial_out;
  logic [WIDTH-1:0] rx_word;

  shift_sequencer #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .start     (start),
    .dir       (dir),
    .abort     (abort),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .shift_en  (shift_en),
    .bit_idx   (bit_idx),
    .q         (q),
    .serial_out(serial_out),
    .rx_word   (rx_word)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] word;
    logic             d;
    int               t0;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  // monitor: serial stream of the current transfer and done pulses
  int   mk;
  int   mj;
  logic mb;
  exp_t me;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mk = cyc - exp_q[0].t0;
      if (mk >= DEPTH && mk < DEPTH + WIDTH) begin
        mj = mk - DEPTH;
        mb = exp_q[0].d ? exp_q[0].word[WIDTH-1-mj]
                        : exp_q[0].word[mj];
        check("serial_out", {31'd0, serial_out}, {31'd0, mb});
      end
    end
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done: unexpected pulse, rx_word=%0h (cycle %0d)",
                 rx_word, cyc);
      end else begin
        me = exp_q.pop_front();
        check("rx_word", 32'(rx_word), 32'(me.word));
        check("latency", 32'(cyc - me.t0), 32'(WIDTH + DEPTH));
      end
    end
  end

  task automatic issue(logic [WIDTH-1:0] w, logic d, bit expect_run);
    exp_t e;
    @(negedge clk);
    data_in = w;
    dir     = d;
    start   = 1'b1;
    if (expect_run) begin
      e.word = w;
      e.d    = d;
      e.t0   = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s: busy stuck, got 1 want 0", name);
    end
  endtask

  task automatic xfer(logic [WIDTH-1:0] w, logic d);
    int n = 0;
    issue(w, d, 1'b1);
    while (busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("busy_len", 32'(n), 32'(WIDTH + DEPTH + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_rx", 32'(rx_word), 32'd0);
    check("rst_idx", 32'(bit_idx), 32'd0);
    check("rst_shen", {31'd0, shift_en}, 32'd0);

    xfer(8'hA5, 1'b0);
    xfer(8'h3C, 1'b1);

    issue(8'h12, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    data_in = 8'hFF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("busy_start");
    check("busy_start_rx", 32'(rx_word), 32'h12);

    issue(8'hF0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_q", 32'(q), 32'd0);
    check("abort_idx", 32'(bit_idx), 32'd0);
    repeat (3) @(negedge clk);
    xfer(8'h0F, 1'b0);

    issue(8'h55, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("clr_q", 32'(q), 32'd0);
    check("clr_rx", 32'(rx_word), 32'd0);
    check("clr_idx", 32'(bit_idx), 32'd0);
    check("clr_shen", {31'd0, shift_en}, 32'd0);

    data_in = 8'hAA;
    clear   = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    check("clrstart_busy", {31'd0, busy}, 32'd0);
    repeat (15) @(negedge clk);
    check("clrstart_idle", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      xfer(WIDTH'($urandom), 1'($urandom));
    end

    repeat (5) @(negedge clk);
    check("pending", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
